// File: rtl/ieeedrv_pkg.sv
// Shared types and sizes for the IEEE drive subdrive responder.
package ieeedrv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int unsigned BLK_BYTES = 256;
    localparam int unsigned BLK_W     = 6;
    localparam int unsigned ADDR_W    = $clog2(BLK_BYTES);
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LBA_W     = 32;
    localparam int unsigned TRK_AW    = BLK_W + ADDR_W;

    localparam logic [BLK_W-1:0] BLK_MAX = '1;

endpackage

// File: rtl/ieeedrv_sd_responder_if.sv
// Subdrive request lines, host block channel and track-buffer port of the responder.
interface ieeedrv_sd_responder_if #(
    parameter int unsigned SUBDRV = 2
) ();
    import ieeedrv_pkg::*;

    localparam int unsigned NS = SUBDRV - 1;

    logic [LBA_W-1:0]  sd_lba     [SUBDRV];
    logic [BLK_W-1:0]  sd_blk_cnt [SUBDRV];
    logic [NS:0]       sd_rd;
    logic [NS:0]       sd_wr;
    logic [NS:0]       sd_ack;

    logic [LBA_W-1:0]  hps_lba;
    logic [BLK_W-1:0]  hps_blk_cnt;
    logic              hps_rd;
    logic              hps_wr;
    logic              hps_ack;
    logic [ADDR_W-1:0] hps_buff_addr;
    logic [DATA_W-1:0] hps_buff_dout;
    logic              hps_buff_wr;
    logic [DATA_W-1:0] hps_buff_din;

    logic [TRK_AW-1:0] trk_addr;
    logic [DATA_W-1:0] trk_dout;
    logic [NS:0]       trk_we;
    logic [DATA_W-1:0] trk_din    [SUBDRV];

    // Responder side.
    modport slave (
        input  sd_lba, sd_blk_cnt, sd_rd, sd_wr,
        input  hps_ack, hps_buff_addr, hps_buff_dout, hps_buff_wr,
        input  trk_din,
        output sd_ack, hps_lba, hps_blk_cnt, hps_rd, hps_wr, hps_buff_din,
        output trk_addr, trk_dout, trk_we
    );

    // Subdrives, host and track RAMs seen together.
    modport master (
        output sd_lba, sd_blk_cnt, sd_rd, sd_wr,
        output hps_ack, hps_buff_addr, hps_buff_dout, hps_buff_wr,
        output trk_din,
        input  sd_ack, hps_lba, hps_blk_cnt, hps_rd, hps_wr, hps_buff_din,
        input  trk_addr, trk_dout, trk_we
    );

endinterface

// File: rtl/ieeedrv_sd_responder.sv
// Arbitrates subdrive track transfers onto the host block channel and steers
// host buffer bytes into or out of the winning subdrive's track buffer.
module ieeedrv_sd_responder
    import ieeedrv_pkg::*;
#(
    parameter int unsigned SUBDRV = 2
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    ieeedrv_sd_responder_if.slave        bus,
    output logic                         busy
);

    localparam int unsigned NS    = SUBDRV - 1;
    localparam int unsigned DRV_W = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;

    state_t            state, state_nxt;
    logic [DRV_W-1:0]  drv, drv_nxt;
    logic [DRV_W-1:0]  rr, rr_nxt;
    logic              dir, dir_nxt;
    logic [BLK_W-1:0]  blk, blk_nxt, blk_cur;
    logic              last_byte, last_byte_nxt;
    logic [LBA_W-1:0]  lba, lba_nxt;
    logic [BLK_W-1:0]  cnt, cnt_nxt;
    logic              hrd, hrd_nxt;
    logic              hwr, hwr_nxt;
    logic [NS:0]       ack, ack_nxt;

    logic [NS:0]       req, req_sh, wr_sh;
    logic [DRV_W-1:0]  idx, pick;
    logic              found;
    logic [LBA_W-1:0]  pick_lba;
    logic [BLK_W-1:0]  pick_cnt;
    logic [DATA_W-1:0] din;
    logic              we_en;

    // Round-robin search starting at rr.
    always_comb begin
        req    = bus.sd_rd | bus.sd_wr;
        found  = 1'b0;
        pick   = '0;
        idx    = '0;
        req_sh = '0;
        for (int unsigned i = 0; i < SUBDRV; i++) begin
            idx    = DRV_W'((32'(rr) + i) % SUBDRV);
            req_sh = req >> idx;
            if (!found && req_sh[0]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        wr_sh = bus.sd_wr >> pick;
    end

    always_comb begin
        pick_lba = '0;
        pick_cnt = '0;
        din      = '0;
        for (int unsigned d = 0; d < SUBDRV; d++) begin
            if (pick == DRV_W'(d)) begin
                pick_lba = bus.sd_lba[d];
                pick_cnt = bus.sd_blk_cnt[d];
            end
            if (drv == DRV_W'(d)) begin
                din = bus.trk_din[d];
            end
        end
    end

    // Block index advances on the 255 -> 0 address wrap, visible in the same cycle.
    always_comb begin
        blk_cur = blk;
        if (state == XFER && last_byte && bus.hps_buff_addr == '0 && blk != BLK_MAX) begin
            blk_cur = blk + BLK_W'(1);
        end
        we_en = (state == XFER) && bus.hps_buff_wr && !dir && (blk_cur <= cnt);
    end

    always_comb begin
        state_nxt     = state;
        drv_nxt       = drv;
        rr_nxt        = rr;
        dir_nxt       = dir;
        blk_nxt       = blk;
        last_byte_nxt = last_byte;
        lba_nxt       = lba;
        cnt_nxt       = cnt;
        hrd_nxt       = hrd;
        hwr_nxt       = hwr;
        ack_nxt       = ack;
        unique case (state)
            IDLE: begin
                if (found) begin
                    drv_nxt   = pick;
                    dir_nxt   = wr_sh[0];
                    lba_nxt   = pick_lba;
                    cnt_nxt   = pick_cnt;
                    hrd_nxt   = !wr_sh[0];
                    hwr_nxt   = wr_sh[0];
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.hps_ack) begin
                    hrd_nxt       = 1'b0;
                    hwr_nxt       = 1'b0;
                    ack_nxt       = SUBDRV'(1) << drv;
                    blk_nxt       = '0;
                    last_byte_nxt = 1'b0;
                    state_nxt     = XFER;
                end
            end
            XFER: begin
                blk_nxt       = blk_cur;
                last_byte_nxt = (bus.hps_buff_addr == '1);
                if (!bus.hps_ack) begin
                    ack_nxt   = '0;
                    rr_nxt    = DRV_W'((32'(drv) + 32'd1) % SUBDRV);
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (!bus.hps_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset while the host still acknowledges parks in DRAIN until it lets go.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= bus.hps_ack ? DRAIN : IDLE;
            drv       <= '0;
            rr        <= '0;
            dir       <= 1'b0;
            blk       <= '0;
            last_byte <= 1'b0;
            lba       <= '0;
            cnt       <= '0;
            hrd       <= 1'b0;
            hwr       <= 1'b0;
            ack       <= '0;
        end else begin
            state     <= state_nxt;
            drv       <= drv_nxt;
            rr        <= rr_nxt;
            dir       <= dir_nxt;
            blk       <= blk_nxt;
            last_byte <= last_byte_nxt;
            lba       <= lba_nxt;
            cnt       <= cnt_nxt;
            hrd       <= hrd_nxt;
            hwr       <= hwr_nxt;
            ack       <= ack_nxt;
        end
    end

    assign bus.sd_ack       = ack;
    assign bus.hps_lba      = lba;
    assign bus.hps_blk_cnt  = cnt;
    assign bus.hps_rd       = hrd;
    assign bus.hps_wr       = hwr;
    assign bus.hps_buff_din = din;
    assign bus.trk_addr     = {blk_cur, bus.hps_buff_addr};
    assign bus.trk_dout     = bus.hps_buff_dout;
    assign bus.trk_we       = SUBDRV'(we_en) << drv;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_ieeedrv_sd_responder.sv
// Bench for ieeedrv_sd_responder: table-driven grants, hand-written corner
// sequences and randomized transfers against a transaction-level model.
module tb_ieeedrv_sd_responder;
    import ieeedrv_pkg::*;

    typedef struct packed {
        logic        d;
        logic [13:0] a;
        logic [7:0]  v;
    } wr_t;

    typedef struct {
        logic [1:0] rd;
        logic [1:0] wr;
        int         exp_d;
        logic       exp_dir;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset;
    logic busy, busy1;
    always #5 clk_sys = ~clk_sys;

    ieeedrv_sd_responder_if #(.SUBDRV(2)) bus ();
    ieeedrv_sd_responder_if #(.SUBDRV(1)) bus1 ();

    ieeedrv_sd_responder #(.SUBDRV(2)) dut (
        .clk_sys(clk_sys), .reset(reset), .bus(bus), .busy(busy));
    ieeedrv_sd_responder #(.SUBDRV(1)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .bus(bus1), .busy(busy1));

    logic [7:0] rmem [2][16384];
    assign bus.trk_din[0]  = rmem[0][bus.trk_addr];
    assign bus.trk_din[1]  = rmem[1][bus.trk_addr];
    assign bus1.trk_din[0] = rmem[0][bus1.trk_addr];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   rr_m   = 0;
    wr_t  got_q[$];
    vec_t tbl [8];

    // Track-RAM write capture, mid-cycle.
    always @(negedge clk_sys) begin
        for (int d = 0; d < 2; d++)
            if (bus.trk_we[d]) got_q.push_back({1'(d), bus.trk_addr, bus.trk_dout});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        rr_m  = 0;
    endtask

    function automatic int model_pick(input logic [1:0] req, input int rr);
        for (int i = 0; i < 2; i++)
            if (req[1'((rr + i) % 2)]) return (rr + i) % 2;
        return 0;
    endfunction

    task automatic run_xfer(input logic [1:0] rd, input logic [1:0] wr,
                            input logic [31:0] l0, input logic [31:0] l1,
                            input logic [5:0] c0, input logic [5:0] c1,
                            input int exp_d, input logic exp_dir,
                            input int nblk, input int gap_pct, input bit clear_all);
        logic [31:0] exp_lba;
        logic [5:0]  exp_cnt;
        logic [7:0]  v;
        logic [13:0] ra;
        logic [1:0]  exp_ack;
        int          t, bad_din, bad_ack, bad_wr;
        wr_t         exp_q[$];
        exp_lba = (exp_d != 0) ? l1 : l0;
        exp_cnt = (exp_d != 0) ? c1 : c0;
        exp_ack = 2'b01 << exp_d;
        bus.sd_lba[0] = l0;
        bus.sd_lba[1] = l1;
        bus.sd_blk_cnt[0] = c0;
        bus.sd_blk_cnt[1] = c1;
        bus.sd_rd = rd;
        bus.sd_wr = wr;
        bus.hps_buff_addr = 8'h00;
        bus.hps_buff_wr = 1'b0;
        t = 0;
        while (!(bus.hps_rd || bus.hps_wr) && t < 8) begin
            tick();
            t++;
        end
        if (t == 8) begin
            chk("grant_timeout", 64'd0, 64'd1);
            bus.sd_rd = 2'b00;
            bus.sd_wr = 2'b00;
            return;
        end
        chk("hps_dir", {bus.hps_rd, bus.hps_wr}, {!exp_dir, exp_dir});
        chk("hps_lba", bus.hps_lba, exp_lba);
        chk("hps_blk_cnt", bus.hps_blk_cnt, exp_cnt);
        repeat ($urandom_range(0, 2)) tick();
        chk("hps_hold", {bus.hps_rd, bus.hps_wr, busy}, {!exp_dir, exp_dir, 1'b1});
        bus.hps_ack = 1'b1;
        tick();
        chk("sd_ack_rise", bus.sd_ack, exp_ack);
        chk("hps_req_drop", {bus.hps_rd, bus.hps_wr}, 2'b00);
        bus.sd_rd[1'(exp_d)] = 1'b0;
        bus.sd_wr[1'(exp_d)] = 1'b0;
        got_q.delete();
        bad_din = 0;
        bad_ack = 0;
        for (int b = 0; b < nblk; b++) begin
            for (int a = 0; a < 256; a++) begin
                while (int'($urandom_range(0, 99)) < gap_pct) begin
                    tick();
                    bus.hps_buff_wr = 1'b0;
                    @(negedge clk_sys);
                    if (bus.sd_ack !== exp_ack) bad_ack++;
                end
                tick();
                v  = 8'($urandom);
                ra = {6'((b > 63) ? 63 : b), 8'(a)};
                bus.hps_buff_addr = 8'(a);
                bus.hps_buff_dout = v;
                bus.hps_buff_wr   = exp_dir ? 1'($urandom) : 1'b1;
                if (!exp_dir && b <= int'(exp_cnt)) exp_q.push_back({1'(exp_d), ra, v});
                @(negedge clk_sys);
                if (exp_dir && bus.hps_buff_din !== rmem[exp_d][ra]) bad_din++;
                if (bus.sd_ack !== exp_ack) bad_ack++;
            end
        end
        tick();
        bus.hps_buff_wr = 1'b0;
        chk("sd_ack_held", 64'(bad_ack), 64'd0);
        if (exp_dir) chk("hps_buff_din", 64'(bad_din), 64'd0);
        chk("trk_we_count", 64'(got_q.size()), 64'(exp_q.size()));
        bad_wr = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad_wr++;
        chk("trk_we_data", 64'(bad_wr), 64'd0);
        if (clear_all) begin
            bus.sd_rd = 2'b00;
            bus.sd_wr = 2'b00;
        end
        bus.hps_ack = 1'b0;
        tick();
        chk("sd_ack_fall", bus.sd_ack, 2'b00);
        chk("idle_after_xfer", {busy, bus.hps_rd, bus.hps_wr}, 3'b000);
        rr_m = (exp_d + 1) % 2;
    endtask

    initial begin
        int cnt_hi;
        int t;
        tbl[0] = '{2'b01, 2'b00, 0, 1'b0};
        tbl[1] = '{2'b00, 2'b10, 1, 1'b1};
        tbl[2] = '{2'b11, 2'b00, 0, 1'b0};
        tbl[3] = '{2'b11, 2'b00, 1, 1'b0};
        tbl[4] = '{2'b01, 2'b01, 0, 1'b1};
        tbl[5] = '{2'b01, 2'b10, 1, 1'b1};
        tbl[6] = '{2'b10, 2'b00, 1, 1'b0};
        tbl[7] = '{2'b00, 2'b11, 0, 1'b1};
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16384; i++) rmem[d][i] = 8'($urandom);

        reset = 1'b1;
        bus.sd_rd = '0; bus.sd_wr = '0; bus.hps_ack = 1'b0;
        bus.sd_lba[0] = '0; bus.sd_lba[1] = '0;
        bus.sd_blk_cnt[0] = '0; bus.sd_blk_cnt[1] = '0;
        bus.hps_buff_addr = '0; bus.hps_buff_dout = '0; bus.hps_buff_wr = 1'b0;
        bus1.sd_rd = '0; bus1.sd_wr = '0; bus1.hps_ack = 1'b0;
        bus1.sd_lba[0] = '0; bus1.sd_blk_cnt[0] = '0;
        bus1.hps_buff_addr = '0; bus1.hps_buff_dout = '0; bus1.hps_buff_wr = 1'b0;
        do_reset();

        chk("rst_sd_ack", bus.sd_ack, 2'b00);
        chk("rst_hps_req", {bus.hps_rd, bus.hps_wr}, 2'b00);
        chk("rst_hps_lba", bus.hps_lba, 32'h0);
        chk("rst_hps_blk_cnt", bus.hps_blk_cnt, 6'h0);
        chk("rst_trk_we", bus.trk_we, 2'b00);
        chk("rst_busy", {busy, busy1}, 2'b00);

        // Single 21-block read into drive 0.
        run_xfer(2'b01, 2'b00, 32'h3A, 32'h0, 6'd20, 6'd0, 0, 1'b0, 21, 0, 1'b1);
        chk("read_pulses", 64'(got_q.size()), 64'd5376);
        if (got_q.size() > 0) chk("read_last_addr", got_q[got_q.size() - 1].a, 14'h14FF);
        else chk("read_last_addr", 64'd0, 64'h14FF);

        // Drive 1 write: host reads track buffer, no track writes.
        run_xfer(2'b00, 2'b10, 32'h0, 32'h77, 6'd0, 6'd0, 1, 1'b1, 1, 10, 1'b1);
        chk("write_no_we", 64'(got_q.size()), 64'd0);

        // Overrun: cnt=1, three blocks streamed.
        run_xfer(2'b01, 2'b00, 32'h100, 32'h0, 6'd1, 6'd0, 0, 1'b0, 3, 0, 1'b1);
        cnt_hi = 0;
        foreach (got_q[i]) if (got_q[i].a >= 14'h0200) cnt_hi++;
        chk("overrun_guard", 64'(cnt_hi), 64'd0);

        do_reset();
        for (int i = 0; i < 8; i++)
            run_xfer(tbl[i].rd, tbl[i].wr, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
                     6'(i), 6'(63 - i), tbl[i].exp_d, tbl[i].exp_dir, 1, 10, 1'b1);

        // Contention: pair with rr=0 -> 0 then 1; after a lone drive-0 transfer, pair -> 1 then 0.
        do_reset();
        run_xfer(2'b11, 2'b00, 32'hA0, 32'hB0, 6'd0, 6'd0, 0, 1'b0, 1, 0, 1'b0);
        run_xfer(2'b10, 2'b00, 32'hA0, 32'hB0, 6'd0, 6'd0, 1, 1'b0, 1, 0, 1'b1);
        run_xfer(2'b01, 2'b00, 32'hA1, 32'hB1, 6'd0, 6'd0, 0, 1'b0, 1, 0, 1'b1);
        run_xfer(2'b11, 2'b00, 32'hA2, 32'hB2, 6'd0, 6'd0, 1, 1'b0, 1, 0, 1'b0);
        run_xfer(2'b01, 2'b00, 32'hA2, 32'hB2, 6'd0, 6'd0, 0, 1'b0, 1, 0, 1'b1);

        // Reset during XFER with hps_ack high.
        do_reset();
        bus.sd_rd = 2'b01;
        bus.sd_wr = 2'b00;
        t = 0;
        while (!bus.hps_rd && t < 8) begin
            tick();
            t++;
        end
        chk("rst_seq_grant", bus.hps_rd, 1'b1);
        bus.hps_ack = 1'b1;
        tick();
        chk("rst_seq_ack", bus.sd_ack, 2'b01);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_seq_sd_ack", bus.sd_ack, 2'b00);
        chk("rst_seq_busy", busy, 1'b1);
        repeat (3) begin
            tick();
            chk("drain_no_req", bus.hps_rd, 1'b0);
        end
        bus.hps_ack = 1'b0;
        tick();
        chk("drain_exit_no_req", bus.hps_rd, 1'b0);
        tick();
        chk("drain_then_req", bus.hps_rd, 1'b1);
        bus.hps_ack = 1'b1;
        tick();
        chk("post_drain_ack", bus.sd_ack, 2'b01);
        bus.sd_rd = 2'b00;
        bus.hps_ack = 1'b0;
        tick();
        tick();
        rr_m = 1;

        for (int n = 0; n < 12; n++) begin
            logic [1:0] rd, wr;
            logic [5:0] c0, c1;
            int d;
            do begin
                rd = 2'($urandom);
                wr = 2'($urandom);
            end while ((rd | wr) == 2'b00);
            c0 = 6'($urandom_range(0, 2));
            c1 = 6'($urandom_range(0, 2));
            d  = model_pick(rd | wr, rr_m);
            run_xfer(rd, wr, $urandom, $urandom, c0, c1, d, wr[1'(d)],
                     int'((d != 0) ? c1 : c0) + 1 + int'($urandom_range(0, 1)), 20, 1'b1);
        end

        // Single-subdrive build: every request lands on drive 0.
        for (int r = 0; r < 2; r++) begin
            bus1.sd_lba[0]     = 32'hCAFE_0000 + 32'(r);
            bus1.sd_blk_cnt[0] = 6'(r + 5);
            bus1.sd_rd         = 1'(r == 0);
            bus1.sd_wr         = 1'(r == 1);
            t = 0;
            while (!(bus1.hps_rd || bus1.hps_wr) && t < 8) begin
                tick();
                t++;
            end
            chk("s1_dir", {bus1.hps_rd, bus1.hps_wr}, (r == 0) ? 2'b10 : 2'b01);
            chk("s1_lba", bus1.hps_lba, 32'hCAFE_0000 + 32'(r));
            chk("s1_blk_cnt", bus1.hps_blk_cnt, 6'(r + 5));
            bus1.hps_ack = 1'b1;
            tick();
            chk("s1_ack", bus1.sd_ack, 1'b1);
            bus1.sd_rd = 1'b0;
            bus1.sd_wr = 1'b0;
            bus1.hps_ack = 1'b0;
            tick();
            chk("s1_ack_fall", {bus1.sd_ack, busy1}, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
